// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer.
//   DEBOUNCE_STAGES_DEFAULT : number of consecutive high samples that qualify a press
//   DEBOUNCE_STAGES_MIN/MAX : legal range for the STAGES parameter
package debounce_pkg;

  localparam int unsigned DEBOUNCE_STAGES_DEFAULT = 3;
  localparam int unsigned DEBOUNCE_STAGES_MIN     = 2;
  localparam int unsigned DEBOUNCE_STAGES_MAX     = 16;

endpackage

// File: rtl/debounce_channel.sv
// Single-channel button debouncer.
// Samples btn into a STAGES+1 deep shift register and emits a one-cycle pulse when the
// newest STAGES samples are high and the sample just before them was low.
// Ports:
//   new_clk : sample clock, all state on rising edge
//   reset   : synchronous active-high clear of the shift register
//   btn     : raw active-high button, asynchronous to new_clk
//   pulse   : one-cycle press pulse, decoded from flop outputs only
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = DEBOUNCE_STAGES_DEFAULT
) (
  input  logic new_clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  // q_q[0] is the newest sample, q_q[STAGES] the oldest.
  logic [STAGES:0] q_q;
  logic [STAGES:0] q_d;

  always_comb begin
    q_d = {q_q[STAGES-1:0], btn};
  end

  always_ff @(posedge new_clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Rising edge of the qualified level: fires once per press, never on hold or release.
  assign pulse = (&q_q[STAGES-1:0]) & ~q_q[STAGES];

endmodule

// File: rtl/dual_button_debouncer.sv
// Two independent push-button debouncers sharing one sample clock.
// Ports:
//   new_clk      : debounce/sample clock
//   reset        : synchronous active-high reset
//   button_right : raw right button (active high)
//   button_left  : raw left button (active high)
//   signal_1     : one-cycle debounced right-press pulse
//   signal_2     : one-cycle debounced left-press pulse
module dual_button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = DEBOUNCE_STAGES_DEFAULT
) (
  input  logic new_clk,
  input  logic reset,
  input  logic button_right,
  input  logic button_left,
  output logic signal_1,
  output logic signal_2
);

  if (STAGES < DEBOUNCE_STAGES_MIN || STAGES > DEBOUNCE_STAGES_MAX) begin : g_bad_stages
    $error("dual_button_debouncer: STAGES out of legal range 2..16");
  end

  debounce_channel #(
    .STAGES(STAGES)
  ) u_right (
    .new_clk(new_clk),
    .reset  (reset),
    .btn    (button_right),
    .pulse  (signal_1)
  );

  debounce_channel #(
    .STAGES(STAGES)
  ) u_left (
    .new_clk(new_clk),
    .reset  (reset),
    .btn    (button_left),
    .pulse  (signal_2)
  );

endmodule

// File: tb/tb_dual_button_debouncer.sv
// Self-checking bench for dual_button_debouncer.
// Reference model: per channel, the length of the current run of high samples since the
// last low sample or reset; a pulse is expected exactly when that run length equals STAGES.
module tb_dual_button_debouncer;

  localparam int unsigned STAGES = 3;

  logic new_clk = 1'b0;
  logic reset = 1'b0;
  logic button_right = 1'b0;
  logic button_left = 1'b0;
  logic signal_1;
  logic signal_2;

  int checks = 0;
  int errors = 0;
  int run_r = 0;
  int run_l = 0;
  int n1 = 0;
  int n2 = 0;

  dual_button_debouncer #(
    .STAGES(STAGES)
  ) dut (
    .new_clk     (new_clk),
    .reset       (reset),
    .button_right(button_right),
    .button_left (button_left),
    .signal_1    (signal_1),
    .signal_2    (signal_2)
  );

  always #5 new_clk = ~new_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One sampling edge with the given inputs, then model update and output check.
  task automatic step(input logic r, input logic l, input logic rst);
    button_right = r;
    button_left  = l;
    reset        = rst;
    @(posedge new_clk);
    #1;
    if (rst) begin
      run_r = 0;
      run_l = 0;
    end else begin
      run_r = r ? ((run_r > int'(STAGES)) ? run_r : run_r + 1) : 0;
      run_l = l ? ((run_l > int'(STAGES)) ? run_l : run_l + 1) : 0;
    end
    if (signal_1 === 1'b1) n1++;
    if (signal_2 === 1'b1) n2++;
    chk("signal_1 vs model", signal_1, logic'(run_r == int'(STAGES)));
    chk("signal_2 vs model", signal_2, logic'(run_l == int'(STAGES)));
  endtask

  task automatic clr_counts();
    n1 = 0;
    n2 = 0;
  endtask

  initial begin
    #2;
    // Reset and idle.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("reset signal_1", signal_1, 1'b0);
    chk("reset signal_2", signal_2, 1'b0);
    clr_counts();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    chk_int("idle pulses right", n1, 0);
    chk_int("idle pulses left", n2, 0);

    // Right press for exactly three edges: pulse right after the third.
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    chk("right edge1 no pulse", signal_1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("right edge2 no pulse", signal_1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("right edge3 pulse", signal_1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("right pulse one cycle", signal_1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk_int("right press pulses", n1, 1);
    chk_int("right press left quiet", n2, 0);

    // Left held for 20 cycles: one pulse only.
    clr_counts();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    chk_int("left hold pulses", n2, 1);
    chk_int("left hold right quiet", n1, 0);

    // Both together: coincident pulses.
    clr_counts();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("both signal_1", signal_1, 1'b1);
    chk("both signal_2", signal_2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    chk_int("both pulses right", n1, 1);
    chk_int("both pulses left", n2, 1);

    // Glitches: 2 high, 1 low, 2 high -> nothing; then 3 high -> one pulse.
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_int("glitch no pulse", n1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_int("after glitch one pulse", n1, 1);

    // Reset mid-qualification with the button still held.
    clr_counts();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("mid reset no pulse", signal_1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("post reset edge2 no pulse", signal_1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("post reset edge3 pulse", signal_1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_int("reset mid qual pulses", n1, 1);

    // Randomized runs on both channels with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0 ? run_r != 0 || $urandom_range(0, 1) == 1 : 0),
           1'($urandom_range(0, 2) == 0 ? $urandom_range(0, 1) : run_l != 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_button_debouncer.md
Name: dual_button_debouncer

Overview:
Debounces two independent push-button inputs (right and left) sampled on the debounce clock `new_clk`. Each input feeds its own shift register of `STAGES+1` D flip-flops; with the default `STAGES`=3 that is four flops per channel. A channel emits a single-cycle pulse once its button has been sampled high for `STAGES` consecutive edges after having been low. The block sits between raw board buttons and the control logic that consumes one press event per physical press.

Parameters:
- `STAGES`, default 3: number of consecutive high samples required to qualify a press. Legal range 2..16. Each channel holds `STAGES+1` flops.

Ports:
- `new_clk`  input  1  debounce/sample clock; all state updates on its rising edge
- `reset`  input  1  synchronous, active-high reset; clears all flops on a rising `new_clk` edge
- `button_right`  input  1  raw right button, active-high, asynchronous to `new_clk`
- `button_left`  input  1  raw left button, active-high, asynchronous to `new_clk`
- `signal_1`  output  1  debounced right-press pulse, one `new_clk` cycle wide
- `signal_2`  output  1  debounced left-press pulse, one `new_clk` cycle wide

Behaviour:
- One clock (`new_clk`). Reset is synchronous and active-high (`reset`).
- Per channel, the shift register is `q[STAGES:0]`. On each posedge: `q[0]` <= button; `q[k]` <= `q[k-1]`. `q[0]` is the newest sample.
- Reset: when `reset`=1 at a posedge, all `q` bits are cleared to 0. Therefore `signal_1`=`signal_2`=0 from that edge onward. Reset has priority over sampling.
- Output is combinational from the flop outputs only (no combinational path from the button pins): pulse = AND of `q[STAGES-1:0]` AND NOT `q[STAGES]`.
- Latency: the pulse goes high immediately after the `STAGES`-th consecutive high sampling edge and stays high exactly one `new_clk` cycle. With `STAGES`=3, a press first sampled at edge N produces a pulse during the cycle between edges N+2 and N+3.
- Held button: exactly one pulse per press, regardless of hold length. No repeat.
- Glitch rejection: a high lasting fewer than `STAGES` consecutive samples produces no pulse. A low dropout inside a held press restarts qualification, and one new pulse follows if the input then stays high for `STAGES` samples.
- Press asserted across reset release: all `q` bits are 0 after reset, so a button held through reset yields one pulse `STAGES` edges after `reset` deasserts.
- Channels are fully independent. Simultaneous presses on both buttons give coincident pulses on `signal_1` and `signal_2`.
- Release behaviour: no output event on release; outputs stay 0 while the button is idle.
- Outputs are X-free after the first reset edge.

Decomposition:
- Shared package `debounce_pkg`: constant `DEBOUNCE_STAGES_DEFAULT` = 3, plus localparams for the legal `STAGES` bounds.
- One sub-module, `debounce_channel` (parameter `STAGES`; ports `new_clk`, `reset`, `btn`, `pulse`). It is instantiated twice: right → `signal_1`, left → `signal_2`.
- Top level checks the `STAGES` range at elaboration and errors out if `STAGES` < 2.

Test Plan:
- Reset, idle: assert `reset` 2 cycles with both buttons 0 → `signal_1`=`signal_2`=0 for 20 cycles.
- Right press: `button_right`=1 for exactly 3 sampling edges, then 0 → `signal_1` pulses once for exactly 1 cycle after the 3rd edge. `signal_2` stays 0. Both outputs are 0 ten cycles later.
- Left press held 20 cycles → `signal_2` pulses exactly once; `signal_1` stays 0.
- Both buttons for 3 edges ({left,right}=2'b11) → `signal_1` and `signal_2` pulse in the same cycle, once each.
- Glitch: `button_right` high for 2 edges, low 1 edge, high 2 edges → no pulse. Then high 3 edges → exactly one pulse.
- Reset mid-qualification: after 2 high samples, assert `reset` 1 cycle with the button still high → no pulse until 3 edges after reset release, then exactly one pulse.
